// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: requester identity and the
// request payload that is muxed onto the single DataMemory port.
package dmem_port_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;

  localparam logic [ALEN-1:0] MMIO_LED_ADDR = 32'hFFFF_0000;

  typedef enum logic {
    ARB_C = 1'b0,
    ARB_D = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [2:0]      funct3;
    logic [ALEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of DataMemory: CPU (C) has fixed priority, the DMA/debug
// port (D) is force-granted after MAX_WAIT lost cycles. Read responses are tagged back.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            c_valid,
  output logic            c_ready,
  input  logic            c_we,
  input  logic [3:0]      c_be,
  input  logic [2:0]      c_funct3,
  input  logic [ALEN-1:0] c_addr,
  input  logic [XLEN-1:0] c_wdata,
  output logic            c_rsp_valid,
  output logic [XLEN-1:0] c_rdata,

  input  logic            d_valid,
  output logic            d_ready,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [2:0]      d_funct3,
  input  logic [ALEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rdata,

  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [2:0]      mem_funct3,
  output logic [ALEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  dmem_req_t        c_req_s;
  dmem_req_t        d_req_s;
  dmem_req_t        gnt_req_s;
  logic             gnt_c_s;
  logic             gnt_d_s;
  logic             granted_s;
  logic             d_force_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_nxt_s;
  logic             rd_pend_r;
  arb_port_e        rd_owner_r;
  arb_port_e        owner_nxt_s;

  assign c_req_s   = '{we: c_we, be: c_be, funct3: c_funct3, addr: c_addr, wdata: c_wdata};
  assign d_req_s   = '{we: d_we, be: d_be, funct3: d_funct3, addr: d_addr, wdata: d_wdata};
  assign d_force_s = (wait_cnt_r == CNT_MAX);

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    gnt_c_s = 1'b0;
    gnt_d_s = 1'b0;
    case ({c_valid, d_valid})
      2'b10: gnt_c_s = rst_n;
      2'b01: gnt_d_s = rst_n;
      2'b11: begin
        gnt_d_s = rst_n & d_force_s;
        gnt_c_s = rst_n & ~d_force_s;
      end
      default: begin
        gnt_c_s = 1'b0;
        gnt_d_s = 1'b0;
      end
    endcase
  end

  assign granted_s = gnt_c_s | gnt_d_s;
  assign c_ready   = gnt_c_s;
  assign d_ready   = gnt_d_s;

  // Payload mux; C payload is presented when idle so the port never floats.
  always_comb begin
    gnt_req_s   = c_req_s;
    owner_nxt_s = ARB_C;
    if (gnt_d_s) begin
      gnt_req_s   = d_req_s;
      owner_nxt_s = ARB_D;
    end else begin
      gnt_req_s   = c_req_s;
      owner_nxt_s = ARB_C;
    end
  end

  assign mem_we     = granted_s & gnt_req_s.we;
  assign mem_be     = gnt_req_s.be;
  assign mem_funct3 = gnt_req_s.funct3;
  assign mem_addr   = gnt_req_s.addr;
  assign mem_wdata  = gnt_req_s.wdata;

  // Starvation counter: counts lost cycles of a waiting D, saturating at the force point.
  always_comb begin
    wait_nxt_s = '0;
    if (d_valid && !gnt_d_s) begin
      if (d_force_s) begin
        wait_nxt_s = wait_cnt_r;
      end else begin
        wait_nxt_s = wait_cnt_r + CNT_W'(1);
      end
    end else begin
      wait_nxt_s = '0;
    end
  end

  // State registers: wait counter and read-response tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
      rd_pend_r  <= 1'b0;
      rd_owner_r <= ARB_C;
    end else begin
      wait_cnt_r <= wait_nxt_s;
      rd_pend_r  <= granted_s & ~gnt_req_s.we;
      rd_owner_r <= owner_nxt_s;
    end
  end

  assign c_rsp_valid = rd_pend_r & (rd_owner_r == ARB_C);
  assign d_rsp_valid = rd_pend_r & (rd_owner_r == ARB_D);
  assign c_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural DataMemory
// (1-cycle read latency, byte-enable writes, funct3 load formatting).
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            c_valid, c_ready, c_we, c_rsp_valid;
  logic [3:0]      c_be;
  logic [2:0]      c_funct3;
  logic [ALEN-1:0] c_addr;
  logic [XLEN-1:0] c_wdata, c_rdata;
  logic            d_valid, d_ready, d_we, d_rsp_valid;
  logic [3:0]      d_be;
  logic [2:0]      d_funct3;
  logic [ALEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata, d_rdata;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [2:0]      mem_funct3;
  logic [ALEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_be(c_be), .c_funct3(c_funct3),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_be(d_be), .d_funct3(d_funct3),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Behavioural DataMemory
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    mem_rdata <= load_fmt(mem[mem_addr[9:2]], mem_addr[1:0], mem_funct3);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic c_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    c_valid = 1'b1; c_we = we; c_funct3 = f3; c_addr = a; c_wdata = wd; c_be = 4'hF;
  endtask

  task automatic d_req(input logic we, input logic [2:0] f3, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
    d_valid = 1'b1; d_we = we; d_funct3 = f3; d_be = be; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    logic exp_d;
    logic prev_d;
    logic prev_any;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    rst_n = 1'b0;
    c_valid = 1'b0; c_we = 1'b0; c_be = 4'h0; c_funct3 = 3'b010; c_addr = 32'h0; c_wdata = 32'h0;
    d_valid = 1'b0; d_we = 1'b0; d_be = 4'h0; d_funct3 = 3'b010; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset: both requesting a write, nothing may be granted
    c_req(1'b1, 3'b010, 32'h0000_0040, 32'h1111_1111);
    d_req(1'b1, 3'b010, 4'hF, 32'h0000_0044, 32'h2222_2222);
    smp();
    chk("rst_c_ready", {31'h0, c_ready}, 32'h0);
    chk("rst_d_ready", {31'h0, d_ready}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_c_rsp", {31'h0, c_rsp_valid}, 32'h0);
    chk("rst_d_rsp", {31'h0, d_rsp_valid}, 32'h0);
    c_valid = 1'b0; d_valid = 1'b0;
    nxt();
    rst_n = 1'b1;

    // 1: C lw 0x100 alone
    nxt();
    c_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    smp();
    chk("t1_c_ready", {31'h0, c_ready}, 32'h1);
    chk("t1_mem_addr", mem_addr, 32'h0000_0100);
    chk("t1_mem_we", {31'h0, mem_we}, 32'h0);
    nxt();
    c_valid = 1'b0;
    smp();
    chk("t1_c_rsp", {31'h0, c_rsp_valid}, 32'h1);
    chk("t1_c_rdata", c_rdata, 32'hC0DE_0040);
    chk("t1_d_rsp", {31'h0, d_rsp_valid}, 32'h0);

    // 3: alternating reads C@0x10, D@0x20, C@0x30
    nxt();
    c_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    smp();
    chk("t3_c_ready0", {31'h0, c_ready}, 32'h1);
    nxt();
    c_valid = 1'b0;
    d_req(1'b0, 3'b010, 4'hF, 32'h0000_0020, 32'h0);
    smp();
    chk("t3_d_ready", {31'h0, d_ready}, 32'h1);
    chk("t3_c_rsp0", {31'h0, c_rsp_valid}, 32'h1);
    chk("t3_c_rdata0", c_rdata, 32'hC0DE_0004);
    chk("t3_d_rsp0", {31'h0, d_rsp_valid}, 32'h0);
    nxt();
    d_valid = 1'b0;
    c_req(1'b0, 3'b010, 32'h0000_0030, 32'h0);
    smp();
    chk("t3_c_ready1", {31'h0, c_ready}, 32'h1);
    chk("t3_d_rsp1", {31'h0, d_rsp_valid}, 32'h1);
    chk("t3_d_rdata1", d_rdata, 32'hC0DE_0008);
    chk("t3_c_rsp1", {31'h0, c_rsp_valid}, 32'h0);
    nxt();
    c_valid = 1'b0;
    smp();
    chk("t3_c_rsp2", {31'h0, c_rsp_valid}, 32'h1);
    chk("t3_c_rdata2", c_rdata, 32'hC0DE_000C);
    chk("t3_d_rsp2", {31'h0, d_rsp_valid}, 32'h0);

    // 4: D sb 0xAB @0x203, then C lbu 0x203
    nxt();
    d_req(1'b1, 3'b000, 4'b1000, 32'h0000_0203, 32'hABAB_ABAB);
    smp();
    chk("t4_mem_we", {31'h0, mem_we}, 32'h1);
    chk("t4_mem_be", {28'h0, mem_be}, 32'h8);
    chk("t4_d_ready", {31'h0, d_ready}, 32'h1);
    nxt();
    d_valid = 1'b0;
    smp();
    chk("t4_d_rsp", {31'h0, d_rsp_valid}, 32'h0);
    chk("t4_c_rsp", {31'h0, c_rsp_valid}, 32'h0);
    nxt();
    c_req(1'b0, 3'b100, 32'h0000_0203, 32'h0);
    smp();
    chk("t4_c_ready", {31'h0, c_ready}, 32'h1);
    nxt();
    c_valid = 1'b0;
    smp();
    chk("t4_c_rsp_lbu", {31'h0, c_rsp_valid}, 32'h1);
    chk("t4_c_rdata_lbu", c_rdata, 32'h0000_00AB);

    // 2: both held valid, MAX_WAIT=4 -> C,C,C,C,D repeating
    nxt();
    c_req(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    d_req(1'b0, 3'b010, 4'hF, 32'h0000_0004, 32'h0);
    prev_d = 1'b0;
    prev_any = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_d = (k % 5 == 4);
      smp();
      chk($sformatf("t2_c_ready_%0d", k), {31'h0, c_ready}, {31'h0, ~exp_d});
      chk($sformatf("t2_d_ready_%0d", k), {31'h0, d_ready}, {31'h0, exp_d});
      chk($sformatf("t2_wait_cnt_%0d", k), 32'(dut.wait_cnt_r), 32'(k % 5));
      chk($sformatf("t2_c_rsp_%0d", k), {31'h0, c_rsp_valid}, {31'h0, prev_any & ~prev_d});
      chk($sformatf("t2_d_rsp_%0d", k), {31'h0, d_rsp_valid}, {31'h0, prev_d});
      prev_d = exp_d;
      prev_any = 1'b1;
      nxt();
    end

    // 6: build wait_cnt back up to MAX_WAIT, then C sw to LED collides with forced D
    for (int j = 0; j < 4; j++) begin
      smp();
      chk($sformatf("t6_c_ready_pre%0d", j), {31'h0, c_ready}, 32'h1);
      nxt();
    end
    c_req(1'b1, 3'b010, MMIO_LED_ADDR, 32'h0000_005A);
    smp();
    chk("t6_wait_cnt", 32'(dut.wait_cnt_r), 32'd4);
    chk("t6_d_ready", {31'h0, d_ready}, 32'h1);
    chk("t6_c_ready", {31'h0, c_ready}, 32'h0);
    chk("t6_mem_we_d", {31'h0, mem_we}, 32'h0);
    chk("t6_mem_addr_d", mem_addr, 32'h0000_0004);
    nxt();
    d_valid = 1'b0;
    smp();
    chk("t6_c_ready_1", {31'h0, c_ready}, 32'h1);
    chk("t6_mem_we_c", {31'h0, mem_we}, 32'h1);
    chk("t6_mem_addr_c", mem_addr, MMIO_LED_ADDR);
    chk("t6_mem_wdata_c", mem_wdata, 32'h0000_005A);
    chk("t6_d_rsp", {31'h0, d_rsp_valid}, 32'h1);
    chk("t6_d_rdata", d_rdata, 32'hC0DE_0001);
    nxt();
    c_valid = 1'b0;
    smp();
    chk("t6_c_rsp_wr", {31'h0, c_rsp_valid}, 32'h0);
    chk("t6_d_rsp_wr", {31'h0, d_rsp_valid}, 32'h0);

    // 5: reset during the response cycle of a C read
    nxt();
    c_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    d_req(1'b0, 3'b010, 4'hF, 32'h0000_0008, 32'h0);
    smp();
    chk("t5_c_ready", {31'h0, c_ready}, 32'h1);
    nxt();
    c_valid = 1'b0;
    d_valid = 1'b0;
    chk("t5_c_rsp_pre", {31'h0, c_rsp_valid}, 32'h1);
    chk("t5_wait_pre", 32'(dut.wait_cnt_r), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_c_rsp_rst", {31'h0, c_rsp_valid}, 32'h0);
    chk("t5_wait_rst", 32'(dut.wait_cnt_r), 32'd0);
    c_valid = 1'b1;
    #1;
    chk("t5_c_ready_rst", {31'h0, c_ready}, 32'h0);
    c_valid = 1'b0;
    nxt();
    smp();
    chk("t5_c_rsp_hold", {31'h0, c_rsp_valid}, 32'h0);
    rst_n = 1'b1;
    nxt();
    c_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    smp();
    chk("t5_c_ready_post", {31'h0, c_ready}, 32'h1);
    nxt();
    c_valid = 1'b0;
    smp();
    chk("t5_c_rsp_post", {31'h0, c_rsp_valid}, 32'h1);
    chk("t5_c_rdata_post", c_rdata, 32'hC0DE_0040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
